// File: rtl/lcd_pattern_pkg.sv
// Shared definitions for the LCD timing/pattern generator: pattern modes, bar colours,
// line/frame length helper and the 565 colour reduction used by the format stage.
package lcd_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_COLORBAR = 2'b00,
        MODE_CHECKER  = 2'b01,
        MODE_GRADIENT = 2'b10,
        MODE_SOLID    = 2'b11
    } pattern_mode_t;

    localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;
    localparam logic [23:0] RGB_BLACK = 24'h000000;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = RGB_WHITE;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

    function automatic logic [11:0] line_total(input logic [10:0] sync_w,
                                               input logic [10:0] back_w,
                                               input logic [10:0] disp_w,
                                               input logic [10:0] front_w);
        return 12'(sync_w) + 12'(back_w) + 12'(disp_w) + 12'(front_w);
    endfunction

    // Truncate to R5G6B5, then refill the dropped LSBs with zeros or with the field's MSBs.
    function automatic logic [23:0] expand565(input logic [23:0] rgb, input logic rep);
        return {rgb[23:19], rep ? rgb[23:21] : 3'b000,
                rgb[15:10], rep ? rgb[15:14] : 2'b00,
                rgb[7:3],   rep ? rgb[7:5]   : 3'b000};
    endfunction

endpackage

// File: rtl/lcd_timing_core.sv
// Panel timing core: h/v counters, registered HS/VS/DE and active-area position,
// frame counter and frame strobe. Also exports the pre-register pixel state.
module lcd_timing_core
    import lcd_pattern_pkg::*;
#(
    parameter logic [10:0] H_SYNC   = 11'd1,
    parameter logic [10:0] H_BACK   = 11'd46,
    parameter logic [10:0] H_DISP   = 11'd800,
    parameter logic [10:0] H_FRONT  = 11'd210,
    parameter logic [10:0] V_SYNC   = 11'd1,
    parameter logic [10:0] V_BACK   = 11'd23,
    parameter logic [10:0] V_DISP   = 11'd480,
    parameter logic [10:0] V_FRONT  = 11'd22,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic        lcd_pclk,
    input  logic        rst_n,
    input  logic        en,
    output logic        de_c,
    output logic [10:0] x_c,
    output logic [10:0] y_c,
    output logic        first_c,
    output logic        lcd_de,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic [15:0] frame_cnt,
    output logic        frame_start
);

    localparam logic [11:0] H_TOTAL = line_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
    localparam logic [11:0] V_TOTAL = line_total(V_SYNC, V_BACK, V_DISP, V_FRONT);
    localparam logic [11:0] H_ACT   = 12'(H_SYNC) + 12'(H_BACK);
    localparam logic [11:0] H_END   = H_ACT + 12'(H_DISP);
    localparam logic [11:0] V_ACT   = 12'(V_SYNC) + 12'(V_BACK);
    localparam logic [11:0] V_END   = V_ACT + 12'(V_DISP);

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic        h_last;
    logic        v_last;
    logic        h_vis;
    logic        v_vis;

    assign h_last  = (h_cnt == H_TOTAL - 12'd1);
    assign v_last  = (v_cnt == V_TOTAL - 12'd1);
    assign h_vis   = (h_cnt >= H_ACT) && (h_cnt < H_END);
    assign v_vis   = (v_cnt >= V_ACT) && (v_cnt < V_END);
    assign de_c    = h_vis && v_vis;
    assign x_c     = de_c ? 11'(h_cnt - H_ACT) : 11'd0;
    assign y_c     = de_c ? 11'(v_cnt - V_ACT) : 11'd0;
    assign first_c = (h_cnt == 12'd0) && (v_cnt == 12'd0);

    // Holding the counters at zero while disabled makes every enable start a fresh frame.
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= 12'd0;
            v_cnt <= 12'd0;
        end else if (!en) begin
            h_cnt <= 12'd0;
            v_cnt <= 12'd0;
        end else if (h_last) begin
            h_cnt <= 12'd0;
            v_cnt <= v_last ? 12'd0 : v_cnt + 12'd1;
        end else begin
            h_cnt <= h_cnt + 12'd1;
        end
    end

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            lcd_de      <= 1'b0;
            lcd_hs      <= ~SYNC_POL;
            lcd_vs      <= ~SYNC_POL;
            pixel_xpos  <= 11'd0;
            pixel_ypos  <= 11'd0;
            frame_start <= 1'b0;
        end else if (!en) begin
            lcd_de      <= 1'b0;
            lcd_hs      <= ~SYNC_POL;
            lcd_vs      <= ~SYNC_POL;
            pixel_xpos  <= 11'd0;
            pixel_ypos  <= 11'd0;
            frame_start <= 1'b0;
        end else begin
            lcd_de      <= de_c;
            lcd_hs      <= (h_cnt < 12'(H_SYNC)) ? SYNC_POL : ~SYNC_POL;
            lcd_vs      <= (v_cnt < 12'(V_SYNC)) ? SYNC_POL : ~SYNC_POL;
            pixel_xpos  <= x_c;
            pixel_ypos  <= y_c;
            frame_start <= first_c;
        end
    end

    // Only a completed frame counts; an aborted frame never reaches the wrap point.
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 16'd0;
        end else if (en && h_last && v_last) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/lcd_pattern_timing_gen.sv
// RGB-LCD timing plus test-pattern source: wraps the timing core with a per-frame
// mode latch, the colorbar/checker/gradient/solid mux and the 565/888 format stage.
module lcd_pattern_timing_gen
    import lcd_pattern_pkg::*;
#(
    parameter logic [10:0] H_SYNC   = 11'd1,
    parameter logic [10:0] H_BACK   = 11'd46,
    parameter logic [10:0] H_DISP   = 11'd800,
    parameter logic [10:0] H_FRONT  = 11'd210,
    parameter logic [10:0] V_SYNC   = 11'd1,
    parameter logic [10:0] V_BACK   = 11'd23,
    parameter logic [10:0] V_DISP   = 11'd480,
    parameter logic [10:0] V_FRONT  = 11'd22,
    parameter logic        SYNC_POL = 1'b0,
    parameter logic        FMT565   = 1'b1,
    parameter logic        PAD_REP  = 1'b0,
    parameter int          CHK_LOG2 = 4
) (
    input  logic        lcd_pclk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic [23:0] solid_rgb,
    output logic        lcd_de,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic [23:0] lcd_rgb,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic [15:0] frame_cnt,
    output logic        frame_start
);

    localparam int          BW    = int'(H_DISP) / 8;
    localparam logic [10:0] BW_M1 = 11'(BW - 1);

    logic          de_c;
    logic          first_c;
    logic [10:0]   x_c;
    logic [10:0]   y_c;
    pattern_mode_t mode_q;
    logic [23:0]   solid_q;
    logic [10:0]   bar_w;
    logic [2:0]    bar_idx;
    logic [23:0]   pattern_rgb;
    logic [23:0]   fmt_rgb;
    logic          unused_pos;

    lcd_timing_core #(
        .H_SYNC   (H_SYNC),
        .H_BACK   (H_BACK),
        .H_DISP   (H_DISP),
        .H_FRONT  (H_FRONT),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK),
        .V_DISP   (V_DISP),
        .V_FRONT  (V_FRONT),
        .SYNC_POL (SYNC_POL)
    ) u_core (
        .lcd_pclk    (lcd_pclk),
        .rst_n       (rst_n),
        .en          (en),
        .de_c        (de_c),
        .x_c         (x_c),
        .y_c         (y_c),
        .first_c     (first_c),
        .lcd_de      (lcd_de),
        .lcd_hs      (lcd_hs),
        .lcd_vs      (lcd_vs),
        .pixel_xpos  (pixel_xpos),
        .pixel_ypos  (pixel_ypos),
        .frame_cnt   (frame_cnt),
        .frame_start (frame_start)
    );

    // Pattern selection only changes at the frame origin so a frame is never mixed.
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_COLORBAR;
            solid_q <= 24'd0;
        end else if (first_c) begin
            mode_q  <= pattern_mode_t'(mode);
            solid_q <= solid_rgb;
        end
    end

    // Bar index tracks the current pixel; it sticks at 7 so leftover pixels stay black.
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            bar_w   <= 11'd0;
            bar_idx <= 3'd0;
        end else if (!en || !de_c) begin
            bar_w   <= 11'd0;
            bar_idx <= 3'd0;
        end else if (bar_idx != 3'd7) begin
            if (bar_w == BW_M1) begin
                bar_w   <= 11'd0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_w <= bar_w + 11'd1;
            end
        end
    end

    always_comb begin
        pattern_rgb = RGB_BLACK;
        case (mode_q)
            MODE_COLORBAR: pattern_rgb = bar_color(bar_idx);
            MODE_CHECKER:  pattern_rgb = (x_c[CHK_LOG2] ^ y_c[CHK_LOG2]) ? RGB_WHITE : RGB_BLACK;
            MODE_GRADIENT: pattern_rgb = {x_c[7:0], y_c[7:0], x_c[7:0] ^ y_c[7:0]};
            MODE_SOLID:    pattern_rgb = solid_q;
            default:       pattern_rgb = RGB_BLACK;
        endcase
    end

    assign fmt_rgb    = FMT565 ? expand565(pattern_rgb, PAD_REP) : pattern_rgb;
    assign unused_pos = ^{x_c, y_c};

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            lcd_rgb <= 24'd0;
        end else if (en && de_c) begin
            lcd_rgb <= fmt_rgb;
        end else begin
            lcd_rgb <= 24'd0;
        end
    end

endmodule
